// File: rtl/time_sync_counter.sv
// time_sync_counter: free-running 64-bit network time with slewed phase adjust,
//   periodic frame ticks and rising-edge event timestamping.
// Latency: load -> time_now next cycle; adjust starts slewing next cycle; capture visible next cycle.
// Backpressure: cap_valid/cap_ready; an edge while the holding register is full sets cap_overrun.
//
// Ports:
//   ACLK, ARESETN            clock, async active-low reset
//   load_valid/load_time     overwrite time (wins over adjust in the same cycle)
//   adj_valid/adj_offset     start a signed slew; ignored while adj_busy
//   adj_busy                 slew in progress
//   tick_period/frame_tick   frame tick every tick_period cycles (0 = off)
//   time_now                 current time (registered)
//   evt_in                   synchronous event; rising edge is timestamped
//   cap_valid/cap_ready      capture handshake
//   cap_time/cap_overrun     captured time, sticky lost-edge flag
module time_sync_counter #(
  parameter int TIME_W      = 64,
  parameter int ADJ_W       = 32,
  parameter int NOMINAL_INC = 10,
  parameter int TICK_W      = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              load_valid,
  input  logic [TIME_W-1:0] load_time,
  input  logic              adj_valid,
  input  logic [ADJ_W-1:0]  adj_offset,
  output logic              adj_busy,
  input  logic [TICK_W-1:0] tick_period,
  output logic [TIME_W-1:0] time_now,
  output logic              frame_tick,
  input  logic              evt_in,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [TIME_W-1:0] cap_time,
  output logic              cap_overrun
);

  typedef enum logic [1:0] {IDLE, SLEW_POS, SLEW_NEG} slew_state_t;

  slew_state_t       state;
  logic [ADJ_W-1:0]  rem;       // remaining slew magnitude in two's complement
  logic [TICK_W-1:0] div_cnt;
  logic [TICK_W-1:0] per_q;     // period in force for the current tick cycle
  logic              evt_d;
  logic [TIME_W-1:0] inc;
  logic              evt_edge;
  logic              cap_hs;

  always_comb begin
    inc = TIME_W'(NOMINAL_INC);
    case (state)
      SLEW_POS: inc = TIME_W'(NOMINAL_INC + 1);
      SLEW_NEG: inc = TIME_W'(NOMINAL_INC - 1);
      default:  inc = TIME_W'(NOMINAL_INC);
    endcase
  end

  // Time counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      time_now <= '0;
    end else if (load_valid) begin
      time_now <= load_time;
    end else begin
      time_now <= time_now + inc;
    end
  end

  // Slew FSM: each slew cycle moves the remainder one step toward zero and
  // drops back to IDLE on the step that reaches zero, so the total shift is
  // exactly adj_offset. adj_busy tracks the next state so it equals state!=IDLE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      rem      <= '0;
      adj_busy <= 1'b0;
    end else if (load_valid) begin
      state    <= IDLE;
      rem      <= '0;
      adj_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (adj_valid && (adj_offset != '0)) begin
            rem      <= adj_offset;
            state    <= adj_offset[ADJ_W-1] ? SLEW_NEG : SLEW_POS;
            adj_busy <= 1'b1;
          end
        end
        SLEW_POS: begin
          rem <= rem - ADJ_W'(1);
          if (rem == ADJ_W'(1)) begin
            state    <= IDLE;
            adj_busy <= 1'b0;
          end
        end
        SLEW_NEG: begin
          rem <= rem + ADJ_W'(1);
          if (rem == '1) begin
            state    <= IDLE;
            adj_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rem      <= '0;
          adj_busy <= 1'b0;
        end
      endcase
    end
  end

  // Frame tick divider. tick_period is only sampled on wrap, load or while the
  // active period is zero, so a mid-period change waits for the next period.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      div_cnt    <= '0;
      per_q      <= '0;
      frame_tick <= 1'b0;
    end else if (load_valid) begin
      div_cnt    <= '0;
      per_q      <= tick_period;
      frame_tick <= 1'b0;
    end else if (per_q == '0) begin
      div_cnt    <= '0;
      per_q      <= tick_period;
      frame_tick <= 1'b0;
    end else if (div_cnt == per_q - TICK_W'(1)) begin
      div_cnt    <= '0;
      per_q      <= tick_period;
      frame_tick <= 1'b1;
    end else begin
      div_cnt    <= div_cnt + TICK_W'(1);
      frame_tick <= 1'b0;
    end
  end

  assign evt_edge = evt_in & ~evt_d;
  assign cap_hs   = cap_valid & cap_ready;

  // Event capture: the holding register may reload in the same cycle its
  // previous contents are handed off.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      evt_d       <= 1'b0;
      cap_valid   <= 1'b0;
      cap_time    <= '0;
      cap_overrun <= 1'b0;
    end else begin
      evt_d <= evt_in;
      if (evt_edge && (!cap_valid || cap_ready)) begin
        cap_time  <= time_now;
        cap_valid <= 1'b1;
      end else if (cap_hs) begin
        cap_valid <= 1'b0;
      end
      if (evt_edge && cap_valid && !cap_ready) begin
        cap_overrun <= 1'b1;
      end else if (cap_hs) begin
        cap_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_time_sync_counter.sv
// tb_time_sync_counter: directed bench for time_sync_counter. Stimulus pushes
//   cycle-stamped expected output values into a scoreboard queue; a monitor on
//   the falling clock edge pops and compares every entry due in that cycle.
module tb_time_sync_counter;

  logic        ACLK;
  logic        ARESETN;
  logic        load_valid;
  logic [63:0] load_time;
  logic        adj_valid;
  logic [31:0] adj_offset;
  logic        adj_busy;
  logic [15:0] tick_period;
  logic [63:0] time_now;
  logic        frame_tick;
  logic        evt_in;
  logic        cap_valid;
  logic        cap_ready;
  logic [63:0] cap_time;
  logic        cap_overrun;

  time_sync_counter dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .load_valid  (load_valid),
    .load_time   (load_time),
    .adj_valid   (adj_valid),
    .adj_offset  (adj_offset),
    .adj_busy    (adj_busy),
    .tick_period (tick_period),
    .time_now    (time_now),
    .frame_tick  (frame_tick),
    .evt_in      (evt_in),
    .cap_valid   (cap_valid),
    .cap_ready   (cap_ready),
    .cap_time    (cap_time),
    .cap_overrun (cap_overrun)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef enum int {F_TIME, F_BUSY, F_TICK, F_CAPV, F_CAPT, F_OVR} fld_t;
  typedef struct {
    int          cyc;
    fld_t        f;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mi;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic string fname(fld_t f);
    case (f)
      F_TIME:  return "time_now";
      F_BUSY:  return "adj_busy";
      F_TICK:  return "frame_tick";
      F_CAPV:  return "cap_valid";
      F_CAPT:  return "cap_time";
      default: return "cap_overrun";
    endcase
  endfunction

  function automatic logic [63:0] actual(fld_t f);
    case (f)
      F_TIME:  return time_now;
      F_BUSY:  return 64'(adj_busy);
      F_TICK:  return 64'(frame_tick);
      F_CAPV:  return 64'(cap_valid);
      F_CAPT:  return cap_time;
      default: return 64'(cap_overrun);
    endcase
  endfunction

  // Monitor: compare everything due this cycle; anything overdue was missed.
  always @(negedge ACLK) begin
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].cyc == cyc) begin
        n_checks++;
        if (actual(sb[mi].f) !== sb[mi].v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h want=%h", fname(sb[mi].f), cyc,
                   actual(sb[mi].f), sb[mi].v);
        end
        sb.delete(mi);
      end else if (sb[mi].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s missed at cyc=%0d want=%h", fname(sb[mi].f), sb[mi].cyc, sb[mi].v);
        sb.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic expect_at(input int off, input fld_t f, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc + off;
    e.f   = f;
    e.v   = v;
    sb.push_back(e);
  endtask

  function automatic int slew_steps(input int k);
    if (k < 1) return 0;
    if (k - 1 > 3) return 3;
    return k - 1;
  endfunction

  initial begin
    ARESETN     = 1'b1;
    load_valid  = 1'b0;
    load_time   = '0;
    adj_valid   = 1'b0;
    adj_offset  = '0;
    tick_period = '0;
    evt_in      = 1'b0;
    cap_ready   = 1'b0;
    #2 ARESETN = 1'b0;
    step(2);

    // Reset values, then five idle cycles counting by 10.
    expect_at(0, F_TIME, 64'h0);
    expect_at(0, F_BUSY, 64'h0);
    expect_at(0, F_TICK, 64'h0);
    expect_at(0, F_CAPV, 64'h0);
    expect_at(0, F_CAPT, 64'h0);
    expect_at(0, F_OVR,  64'h0);
    ARESETN = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expect_at(k, F_TIME, 64'(10 * k));
      expect_at(k, F_TICK, 64'h0);
      expect_at(k, F_CAPV, 64'h0);
    end
    step(5);

    // Load 0x1000, slew +3; a +100 adjust while busy is ignored.
    load_valid = 1'b1;
    load_time  = 64'h1000;
    step(1);
    load_valid = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      expect_at(k, F_TIME, 64'h1000 + 64'(10 * k) + 64'(slew_steps(k)));
      expect_at(k, F_BUSY, 64'((k >= 1 && k <= 3) ? 1 : 0));
    end
    adj_valid  = 1'b1;
    adj_offset = 32'd3;
    step(1);
    adj_valid  = 1'b0;
    step(1);
    adj_valid  = 1'b1;
    adj_offset = 32'd100;
    step(2);
    adj_valid  = 1'b0;
    step(4);

    // Load 0x2000, slew -3.
    load_valid = 1'b1;
    load_time  = 64'h2000;
    step(1);
    load_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      expect_at(k, F_TIME, 64'h2000 + 64'(10 * k) - 64'(slew_steps(k)));
      expect_at(k, F_BUSY, 64'((k >= 1 && k <= 3) ? 1 : 0));
    end
    adj_valid  = 1'b1;
    adj_offset = 32'hFFFF_FFFD;
    step(1);
    adj_valid  = 1'b0;
    step(6);

    // Wrap on load near 2^64, with a same-cycle adjust that must be dropped.
    load_valid = 1'b1;
    load_time  = 64'hFFFF_FFFF_FFFF_FFFB;
    adj_valid  = 1'b1;
    adj_offset = 32'd5;
    step(1);
    load_valid = 1'b0;
    adj_valid  = 1'b0;
    expect_at(0, F_TIME, 64'hFFFF_FFFF_FFFF_FFFB);
    expect_at(1, F_TIME, 64'h5);
    expect_at(2, F_TIME, 64'hF);
    for (int k = 0; k <= 3; k++) expect_at(k, F_BUSY, 64'h0);
    step(4);

    // Ticks: period 4, switched to 2 mid-period, then off.
    tick_period = 16'd4;
    load_valid  = 1'b1;
    load_time   = 64'h0;
    for (int k = 1; k <= 19; k++)
      expect_at(k, F_TICK, 64'((k == 5 || k == 9 || k == 13 || k == 15 || k == 17 || k == 19) ? 1 : 0));
    step(1);
    load_valid  = 1'b0;
    step(9);
    tick_period = 16'd2;
    step(10);
    tick_period = 16'd0;
    load_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) expect_at(k, F_TICK, 64'h0);
    step(1);
    load_valid  = 1'b0;
    step(8);

    // Capture: edge at time 0x200, overrun, handshake, reload on handshake.
    load_valid = 1'b1;
    load_time  = 64'h1F6;
    expect_at(2,  F_TIME, 64'h200);
    expect_at(3,  F_CAPV, 64'h1);
    expect_at(3,  F_CAPT, 64'h200);
    expect_at(3,  F_OVR,  64'h0);
    expect_at(5,  F_CAPV, 64'h1);
    expect_at(5,  F_CAPT, 64'h200);
    expect_at(5,  F_OVR,  64'h1);
    expect_at(6,  F_CAPV, 64'h1);
    expect_at(6,  F_OVR,  64'h1);
    expect_at(7,  F_CAPV, 64'h0);
    expect_at(7,  F_OVR,  64'h0);
    expect_at(9,  F_CAPV, 64'h1);
    expect_at(9,  F_CAPT, 64'h23C);
    expect_at(11, F_CAPV, 64'h1);
    expect_at(11, F_CAPT, 64'h250);
    expect_at(11, F_OVR,  64'h0);
    expect_at(12, F_CAPV, 64'h0);
    step(1);
    load_valid = 1'b0;
    step(1);
    evt_in = 1'b1;
    step(1);
    evt_in = 1'b0;
    step(1);
    evt_in = 1'b1;
    step(1);
    evt_in = 1'b0;
    step(1);
    cap_ready = 1'b1;
    step(1);
    cap_ready = 1'b0;
    step(1);
    evt_in = 1'b1;
    step(1);
    evt_in = 1'b0;
    step(1);
    evt_in    = 1'b1;
    cap_ready = 1'b1;
    step(1);
    evt_in = 1'b0;
    step(1);
    cap_ready = 1'b0;

    // Reset mid-slew with a pending capture and ticks running.
    tick_period = 16'd1;
    adj_valid   = 1'b1;
    adj_offset  = 32'd50;
    step(1);
    adj_valid = 1'b0;
    evt_in    = 1'b1;
    step(1);
    evt_in = 1'b0;
    expect_at(0, F_TICK, 64'h1);
    expect_at(0, F_BUSY, 64'h1);
    expect_at(0, F_CAPV, 64'h1);
    step(1);
    ARESETN = 1'b0;
    expect_at(0, F_TIME, 64'h0);
    expect_at(0, F_BUSY, 64'h0);
    expect_at(0, F_TICK, 64'h0);
    expect_at(0, F_CAPV, 64'h0);
    expect_at(0, F_CAPT, 64'h0);
    expect_at(0, F_OVR,  64'h0);
    tick_period = 16'd0;
    step(1);
    ARESETN = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      expect_at(k, F_TIME, 64'(10 * k));
      expect_at(k, F_BUSY, 64'h0);
      expect_at(k, F_CAPV, 64'h0);
    end
    step(5);

    foreach (sb[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s never checked cyc=%0d want=%h", fname(sb[i].f), sb[i].cyc, sb[i].v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
